// File: rtl/maxpool_layer.sv
// Streaming 1-D max pooling over POOL_SIZE-word windows of a FRAME_LENGTH-word frame,
// N_CHANNELS signed lanes in parallel, with a single-entry registered output stage.

module maxpool_lane #(
    parameter int WORD_SIZE = 16,
    parameter int RELU      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        first,
    input  logic                        close,
    input  logic signed [WORD_SIZE-1:0] din,
    output logic        [WORD_SIZE-1:0] dout
);
    logic signed [WORD_SIZE-1:0] acc, mx, res;

    // A window's first word ignores the stale accumulator; ties keep acc.
    always_comb begin
        mx  = (first || din > acc) ? din : acc;
        res = (RELU != 0 && mx < 0) ? '0 : mx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            dout <= '0;
        end else if (load) begin
            acc <= mx;
            if (close) dout <= res;
        end
    end
endmodule

module maxpool_layer #(
    parameter int N_CHANNELS   = 1,
    parameter int WORD_SIZE    = 16,
    parameter int POOL_SIZE    = 2,
    parameter int FRAME_LENGTH = 4,
    parameter int RELU         = 0
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    output logic                             pool_ready_o,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [N_CHANNELS*WORD_SIZE-1:0]  data_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [N_CHANNELS*WORD_SIZE-1:0]  data_o
);
    localparam int WCW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int FCW = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state;
    logic [WCW-1:0] win_cnt;
    logic [FCW-1:0] frame_cnt;
    logic           win_first, frame_last, closing, hs_in, hs_out;

    assign win_first    = (win_cnt == '0);
    assign frame_last   = (frame_cnt == FCW'(FRAME_LENGTH - 1));
    assign closing      = (win_cnt == WCW'(POOL_SIZE - 1)) || frame_last;
    // Stall only the closing beat, and only when the output slot is still occupied.
    assign ready_o      = (state == RUN) && !(closing && valid_o && !ready_i);
    assign pool_ready_o = (state == IDLE);
    assign hs_in        = valid_i && ready_o;
    assign hs_out       = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            win_cnt   <= '0;
            frame_cnt <= '0;
            valid_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    win_cnt   <= '0;
                    frame_cnt <= '0;
                    if (start_i) state <= RUN;
                end
                RUN: begin
                    if (hs_in) begin
                        win_cnt   <= closing ? '0 : win_cnt + WCW'(1);
                        frame_cnt <= frame_last ? '0 : frame_cnt + FCW'(1);
                        if (frame_last) state <= DRAIN;
                    end
                end
                DRAIN: if (hs_out) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (hs_in && closing) valid_o <= 1'b1;
            else if (hs_out)      valid_o <= 1'b0;
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_lane
        maxpool_lane #(.WORD_SIZE(WORD_SIZE), .RELU(RELU)) u_lane (
            .clk   (clk_i),
            .rst_n (reset_n_i),
            .load  (hs_in),
            .first (win_first),
            .close (closing),
            .din   (data_i[c*WORD_SIZE +: WORD_SIZE]),
            .dout  (data_o[c*WORD_SIZE +: WORD_SIZE])
        );
    end
endmodule
